// File: rtl/subckt_share_sched_if.sv
// Handshake bundle between the stimulus requesters / result consumer and the
// shared sub-circuit scheduler.
interface subckt_share_sched_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_op;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_data;
  logic [ID_W-1:0]   rsp_id;

  modport master (
    output req_valid, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/subckt_share_sched.sv
// Round-robin scheduler time-sharing a single instance of the power-benchmark
// sub-circuit f(a,b,c,d) = (a^d) & (a^(b&c)), with activity counters.

module subckt_share_f (
  input  logic [3:0] op,
  output logic       y
);
  // op bit0=a, bit1=b, bit2=c, bit3=d
  assign y = (op[0] ^ op[3]) & (op[0] ^ (op[1] & op[2]));
endmodule

module subckt_share_sched #(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  subckt_share_sched_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     stat_grants,
  output logic [CNT_W-1:0]     stat_toggles
);
  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_reg;
  logic [3:0]        op_reg;
  logic              prev_result;
  logic              rsp_valid_q;
  logic              rsp_data_q;
  logic [ID_W-1:0]   rsp_id_q;

  logic              gnt_hit;
  logic [ID_W-1:0]   gnt_idx;
  logic [3:0]        gnt_op;
  logic              f_y;
  int                idx;

  // Search starts one past the last winner so every valid requester is
  // reached within NREQ grants.
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!gnt_hit && bus.req_valid[ID_W'(idx)]) begin
        gnt_hit = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

  assign gnt_op = bus.req_op[4*int'(gnt_idx) +: 4];

  // Grant is visible in the same cycle it is taken; forced low while in reset.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && !rst && gnt_hit)
      bus.req_ready[gnt_idx] = 1'b1;
  end

  subckt_share_f u_f (
    .op (op_reg),
    .y  (f_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= ID_W'(NREQ-1);
      id_reg       <= '0;
      op_reg       <= '0;
      prev_result  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 1'b0;
      rsp_id_q     <= '0;
      busy         <= 1'b0;
      stat_grants  <= '0;
      stat_toggles <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_hit) begin
            op_reg <= gnt_op;
            id_reg <= gnt_idx;
            rr_ptr <= gnt_idx;
            busy   <= 1'b1;
            if (stat_grants != '1)
              stat_grants <= stat_grants + CNT_W'(1);
            state  <= EVAL;
          end
        end
        EVAL: begin
          rsp_data_q  <= f_y;
          rsp_id_q    <= id_reg;
          rsp_valid_q <= 1'b1;
          if (f_y != prev_result && stat_toggles != '1)
            stat_toggles <= stat_toggles + CNT_W'(1);
          prev_result <= f_y;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_subckt_share_sched.sv
// Directed self-checking bench for subckt_share_sched (NREQ=4) plus a
// CNT_W=2 instance for counter saturation.
module tb_subckt_share_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  subckt_share_sched_if #(.NREQ(4), .ID_W(2)) bus ();
  subckt_share_sched_if #(.NREQ(4), .ID_W(2)) bus2 ();

  logic        busy, busy2;
  logic [15:0] stat_grants, stat_toggles;
  logic [1:0]  stat_grants2, stat_toggles2;

  subckt_share_sched #(.NREQ(4), .ID_W(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .busy(busy),
    .stat_grants(stat_grants), .stat_toggles(stat_toggles)
  );

  subckt_share_sched #(.NREQ(4), .ID_W(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .busy(busy2),
    .stat_grants(stat_grants2), .stat_toggles(stat_toggles2)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    bus.req_valid = '0; bus.req_op = '0; bus.rsp_ready = 1'b0;
    bus2.req_valid = '0; bus2.req_op = '0; bus2.rsp_ready = 1'b0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, busy} !== 5'b0)
      $display("FAIL reset_outputs got %b want 00000", {bus.rsp_valid, bus.rsp_data, bus.rsp_id, busy});
    else pass_cnt++;
    total_cnt++;
    if ({stat_grants, stat_toggles} !== 32'h0)
      $display("FAIL reset_counters got %h want 0", {stat_grants, stat_toggles});
    else pass_cnt++;
    bus.req_valid = 4'b0001;
    #1;
    total_cnt++;
    if (bus.req_ready !== 4'b0001) $display("FAIL reset_priority got %b want 0001", bus.req_ready);
    else pass_cnt++;
    bus.req_valid = '0;
  endtask

  task automatic test_single;
    do_reset;
    bus.req_op = 16'h0700;
    bus.req_valid = 4'b0100;
    #1;
    total_cnt++;
    if (bus.req_ready !== 4'b0100) $display("FAIL single_grant got %b want 0100", bus.req_ready);
    else pass_cnt++;
    tick;
    bus.req_valid = '0;
    #1;
    total_cnt++;
    if ({bus.req_ready, bus.rsp_valid, busy} !== 6'b000001)
      $display("FAIL single_eval got %b want 000001", {bus.req_ready, bus.rsp_valid, busy});
    else pass_cnt++;
    tick;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== 4'b1010)
      $display("FAIL single_rsp got %b want 1010", {bus.rsp_valid, bus.rsp_data, bus.rsp_id});
    else pass_cnt++;
    total_cnt++;
    if (stat_grants !== 16'd1 || stat_toggles !== 16'd0)
      $display("FAIL single_stats got %0d/%0d want 1/0", stat_grants, stat_toggles);
    else pass_cnt++;
    bus.rsp_ready = 1'b1;
    tick;
    total_cnt++;
    if ({bus.rsp_valid, busy} !== 2'b00) $display("FAIL single_done got %b want 00", {bus.rsp_valid, busy});
    else pass_cnt++;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_round_robin;
    int gid[4]; int gcyc[4]; logic rdat[4];
    int ng, nr;
    logic [3:0] clr;
    logic [3:0] exp_res;
    ng = 0; nr = 0;
    do_reset;
    bus.rsp_ready = 1'b1;
    bus.req_op = 16'hF01E;
    bus.req_valid = 4'b1111;
    #1;
    for (int cyc = 0; cyc < 40 && (ng < 4 || nr < 4); cyc++) begin
      clr = '0;
      if (bus.req_ready != 4'b0 && ng < 4) begin
        gid[ng] = oh_idx(bus.req_ready); gcyc[ng] = cyc; ng++;
        clr = bus.req_ready;
      end
      if (bus.rsp_valid && nr < 4) begin rdat[nr] = bus.rsp_data; nr++; end
      tick;
      bus.req_valid = bus.req_valid & ~clr;
      #1;
    end
    total_cnt++;
    if (ng != 4 || nr != 4) $display("FAIL rr_timeout grants %0d results %0d want 4/4", ng, nr);
    else begin
      pass_cnt++;
      exp_res = 4'b0011;
      for (int k = 0; k < 4; k++) begin
        total_cnt++;
        if (gid[k] != k) $display("FAIL rr_order[%0d] got %0d want %0d", k, gid[k], k);
        else pass_cnt++;
        total_cnt++;
        if (rdat[k] !== exp_res[k]) $display("FAIL rr_result[%0d] got %b want %b", k, rdat[k], exp_res[k]);
        else pass_cnt++;
        if (k > 0) begin
          total_cnt++;
          if (gcyc[k] - gcyc[k-1] != 3) $display("FAIL rr_gap[%0d] got %0d want 3", k, gcyc[k] - gcyc[k-1]);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (stat_grants !== 16'd4 || stat_toggles !== 16'd2)
      $display("FAIL rr_stats got %0d/%0d want 4/2", stat_grants, stat_toggles);
    else pass_cnt++;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_stall;
    do_reset;
    bus.req_op = 16'h5010;
    bus.req_valid = 4'b1010;
    #1;
    total_cnt++;
    if (bus.req_ready !== 4'b0010) $display("FAIL stall_grant got %b want 0010", bus.req_ready);
    else pass_cnt++;
    tick;
    bus.req_valid = 4'b1000;
    tick;
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready} !== 8'b1101_0000)
        $display("FAIL stall_hold[%0d] got %b want 11010000", k, {bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.req_ready});
      else pass_cnt++;
      tick;
    end
    bus.rsp_ready = 1'b1;
    tick;
    total_cnt++;
    if ({bus.rsp_valid, bus.req_ready} !== 5'b0_1000)
      $display("FAIL stall_release got %b want 01000", {bus.rsp_valid, bus.req_ready});
    else pass_cnt++;
    tick;
    bus.req_valid = '0;
    total_cnt++;
    if (busy !== 1'b1 || stat_grants !== 16'd2)
      $display("FAIL stall_next got busy=%b grants=%0d want 1/2", busy, stat_grants);
    else pass_cnt++;
    repeat (3) tick;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_reset;
    bus.req_op = 16'h000E;
    bus.req_valid = 4'b0001;
    tick;
    bus.req_valid = '0;
    tick;
    total_cnt++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 1'b1)
      $display("FAIL mid_pre got %b%b want 11", bus.rsp_valid, bus.rsp_data);
    else pass_cnt++;
    bus.req_valid = 4'b1010;
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_data, busy, bus.req_ready} !== 7'b0)
      $display("FAIL mid_async got %b want 0000000", {bus.rsp_valid, bus.rsp_data, busy, bus.req_ready});
    else pass_cnt++;
    total_cnt++;
    if (stat_grants !== 16'd0 || stat_toggles !== 16'd0)
      $display("FAIL mid_counters got %0d/%0d want 0/0", stat_grants, stat_toggles);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if (bus.req_ready !== 4'b0010) $display("FAIL mid_regrant got %b want 0010", bus.req_ready);
    else pass_cnt++;
    tick;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_saturation;
    bit ok;
    do_reset;
    bus2.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus2.req_op = (k % 2 == 0) ? 16'h000E : 16'h0000;
      bus2.req_valid = 4'b0001;
      #1;
      ok = 1'b0;
      for (int w = 0; w < 10 && !ok; w++) begin
        if (bus2.req_ready[0]) ok = 1'b1;
        else tick;
      end
      total_cnt++;
      if (!ok) $display("FAIL sat_grant_timeout[%0d] got none want grant", k);
      else pass_cnt++;
      tick;
      bus2.req_valid = '0;
      ok = 1'b0;
      for (int w = 0; w < 10 && !ok; w++) begin
        if (bus2.rsp_valid) ok = 1'b1;
        else tick;
      end
      total_cnt++;
      if (!ok || bus2.rsp_data !== ((k % 2 == 0) ? 1'b1 : 1'b0))
        $display("FAIL sat_result[%0d] got %b want %b", k, bus2.rsp_data, (k % 2 == 0));
      else pass_cnt++;
      tick;
    end
    total_cnt++;
    if (stat_grants2 !== 2'd3 || stat_toggles2 !== 2'd3)
      $display("FAIL sat_counters got %0d/%0d want 3/3", stat_grants2, stat_toggles2);
    else pass_cnt++;
    bus2.rsp_ready = 1'b0;
  endtask

  task automatic test_fairness;
    int gid[8];
    int ng;
    ng = 0;
    do_reset;
    bus.rsp_ready = 1'b1;
    bus.req_op = 16'h1234;
    bus.req_valid = 4'b1111;
    #1;
    for (int cyc = 0; cyc < 60 && ng < 8; cyc++) begin
      if (bus.req_ready != 4'b0) begin gid[ng] = oh_idx(bus.req_ready); ng++; end
      tick;
    end
    bus.req_valid = '0;
    total_cnt++;
    if (ng != 8) $display("FAIL fair_timeout got %0d grants want 8", ng);
    else begin
      pass_cnt++;
      for (int k = 0; k < 8; k++) begin
        total_cnt++;
        if (gid[k] != k % 4 || (k > 0 && gid[k] == gid[k-1]))
          $display("FAIL fair_order[%0d] got %0d want %0d", k, gid[k], k % 4);
        else pass_cnt++;
      end
    end
    repeat (4) tick;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    test_reset;
    test_single;
    test_round_robin;
    test_stall;
    test_reset_mid;
    test_saturation;
    test_fairness;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
